// File: rtl/dispensador_entrega_if.sv
// Handshake bundle between the vending FSM, the product motors and the coin ejector.
// The master side issues orders and acknowledges coins; the dispenser uses the slave side.
interface dispensador_entrega_if #(
  parameter int CAMBIO_W = 2
);
  logic                listo;
  logic [1:0]          producto;
  logic [CAMBIO_W-1:0] cambio;
  logic [2:0]          motor;
  logic                eject_req;
  logic                eject_val;
  logic                eject_ack;
  logic                busy;
  logic                hecho;
  logic                perdido;
  logic                error;

  modport master (
    output listo, producto, cambio, eject_ack,
    input  motor, eject_req, eject_val, busy, hecho, perdido, error
  );

  modport slave (
    input  listo, producto, cambio, eject_ack,
    output motor, eject_req, eject_val, busy, hecho, perdido, error
  );
endinterface

// File: rtl/dispensador_entrega.sv
// Delivery stage: runs the chosen product motor for a fixed time, then pays change greedily.
// Define DISP_TIMEOUT_EN to abandon a coin when the ejector does not acknowledge in time.
module dispensador_entrega #(
  parameter int MOTOR_CYCLES   = 8,
  parameter int CAMBIO_W       = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                  clk,
  input logic                  rst,
  dispensador_entrega_if.slave bus
);
  localparam int MC_W = $clog2(MOTOR_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MOTOR_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MOTOR, PAGA, ESPERA, FIN} state_t;

  state_t              state, state_n;
  logic [1:0]          prod_r, prod_n;
  logic [CAMBIO_W-1:0] rest_r, rest_n;
  logic [MC_W-1:0]     motor_cnt, motor_cnt_n;
  logic [TO_W-1:0]     wait_cnt, wait_cnt_n;
  logic [2:0]          motor_r, motor_n;
  logic                req_r, val_r, val_n;
  logic                busy_r, hecho_r;
  logic                perdido_r, perdido_n;
  logic                error_r, error_n;

  // Next state plus the next value of every registered output, so outputs leave flops directly.
  always_comb begin
    state_n     = state;
    prod_n      = prod_r;
    rest_n      = rest_r;
    motor_cnt_n = motor_cnt;
    wait_cnt_n  = wait_cnt;
    val_n       = val_r;
    error_n     = error_r;
    perdido_n   = perdido_r | (bus.listo & (state != IDLE));
    motor_n     = 3'b000;

    case (state)
      IDLE: begin
        if (bus.listo) begin
          prod_n = bus.producto;
          rest_n = bus.cambio;
          if (bus.producto != 2'b00) begin
            state_n     = MOTOR;
            motor_cnt_n = MC_LOAD;
          end else if (bus.cambio != '0) begin
            state_n = PAGA;
          end else begin
            state_n = FIN;
          end
        end
      end
      MOTOR: begin
        motor_cnt_n = motor_cnt - MC_W'(1);
        if (motor_cnt <= MC_W'(1)) state_n = PAGA;
      end
      PAGA: begin
        if (rest_r == '0) begin
          state_n = FIN;
        end else begin
          // Greedy: a 2-unit coin only when at least 2 units remain, so rest_r cannot underflow.
          val_n      = ({1'b0, rest_r} >= (CAMBIO_W + 1)'(2));
          wait_cnt_n = '0;
          state_n    = ESPERA;
        end
      end
      ESPERA: begin
        if (bus.eject_ack) begin
          rest_n  = rest_r - (val_r ? CAMBIO_W'(2) : CAMBIO_W'(1));
          state_n = PAGA;
        end else if (wait_cnt != TO_LAST) begin
          wait_cnt_n = wait_cnt + TO_W'(1);
        end
`ifdef DISP_TIMEOUT_EN
        else begin
          state_n = FIN;
          error_n = 1'b1;
        end
`endif
      end
      FIN: begin
        val_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state_n == MOTOR) begin
      case (prod_n)
        2'b01:   motor_n = 3'b001;
        2'b10:   motor_n = 3'b010;
        2'b11:   motor_n = 3'b100;
        default: motor_n = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prod_r    <= '0;
      rest_r    <= '0;
      motor_cnt <= '0;
      wait_cnt  <= '0;
      motor_r   <= '0;
      req_r     <= 1'b0;
      val_r     <= 1'b0;
      busy_r    <= 1'b0;
      hecho_r   <= 1'b0;
      perdido_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state     <= state_n;
      prod_r    <= prod_n;
      rest_r    <= rest_n;
      motor_cnt <= motor_cnt_n;
      wait_cnt  <= wait_cnt_n;
      motor_r   <= motor_n;
      req_r     <= (state_n == ESPERA);
      val_r     <= val_n;
      busy_r    <= (state_n != IDLE);
      hecho_r   <= (state_n == FIN);
      perdido_r <= perdido_n;
      error_r   <= error_n;
    end
  end

  assign bus.motor     = motor_r;
  assign bus.eject_req = req_r;
  assign bus.eject_val = val_r;
  assign bus.busy      = busy_r;
  assign bus.hecho     = hecho_r;
  assign bus.perdido   = perdido_r;
  assign bus.error     = error_r;
endmodule
